// File: rtl/pin_entry_auth_pkg.sv
// Shared definitions for the PIN entry/verification stage: state encoding,
// keypad code constants and default sizing.
package pin_entry_auth_pkg;

  localparam int DEFAULT_DIGITS    = 4;
  localparam int DEFAULT_MAX_TRIES = 3;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Idle-cycle counter: counts while enabled, restarts on clear, and flags
// expiry while the count sits at TIMEOUT_CYC-1.
module inactivity_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so expire stays asserted until the owner reacts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/pin_entry_auth.sv
// PIN collection and verification: gathers keypad digits after a card
// session starts, compares against the latched card PIN, counts failures.
module pin_entry_auth
  import pin_entry_auth_pkg::*;
#(
  parameter int DIGITS      = DEFAULT_DIGITS,
  parameter int MAX_TRIES   = DEFAULT_MAX_TRIES,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [4*DIGITS-1:0] stored_pin,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                key_ready,
  output logic                pin_ok,
  output logic                pin_bad,
  output logic                timeout,
  output logic                card_retain,
  output logic                busy,
  output logic [2:0]          tries_left,
  output state_t              state_dbg
);

  // Handshake: a key transfers on a clock edge where key_valid && key_ready;
  // while key_ready is low the source holds key_code and key_valid.

  localparam int PW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   digit_buf_q, digit_buf_d;
  logic [PW-1:0]   pin_q, pin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      tries_q, tries_d;
  logic            ok_d, bad_d, to_d;
  logic            key_live;
  logic            expire;

  // Codes 0xC-0xF are consumed but deliberately do not count as activity.
  assign key_live = key_valid && key_ready &&
                    (is_digit(key_code) || (key_code == KEY_ENTER) || (key_code == KEY_CLEAR));

  inactivity_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q != ST_COLLECT) || key_live),
    .enable (state_q == ST_COLLECT),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      digit_buf_q <= '0;
      pin_q       <= '0;
      cnt_q       <= '0;
      tries_q     <= '0;
      pin_ok      <= 1'b0;
      pin_bad     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_buf_q <= digit_buf_d;
      pin_q       <= pin_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      pin_ok      <= ok_d;
      pin_bad     <= bad_d;
      timeout     <= to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_buf_d = digit_buf_q;
    pin_d       = pin_q;
    cnt_d       = cnt_q;
    tries_d     = tries_q;
    ok_d        = 1'b0;
    bad_d       = 1'b0;
    to_d        = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      digit_buf_d = '0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pin_d       = stored_pin;
            digit_buf_d = '0;
            cnt_d       = '0;
            tries_d     = 3'(MAX_TRIES);
            state_d     = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // A live key beats a simultaneous timer expiry.
          if (key_live) begin
            if (is_digit(key_code)) begin
              if (cnt_q < CW'(DIGITS)) begin
                digit_buf_d = {digit_buf_q[PW-5:0], key_code};
                cnt_d       = cnt_q + 1'b1;
              end
            end else if (key_code == KEY_CLEAR) begin
              digit_buf_d = '0;
              cnt_d       = '0;
            end else begin
              state_d = ST_CHECK;
            end
          end else if (expire) begin
            to_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if ((cnt_q == CW'(DIGITS)) && (digit_buf_q == pin_q)) begin
            ok_d    = 1'b1;
            state_d = ST_IDLE;
          end else if (tries_q > 3'd1) begin
            tries_d     = tries_q - 3'd1;
            bad_d       = 1'b1;
            digit_buf_d = '0;
            cnt_d       = '0;
            state_d     = ST_COLLECT;
          end else begin
            tries_d = 3'd0;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign key_ready   = (state_q == ST_COLLECT);
  assign busy        = (state_q == ST_COLLECT) || (state_q == ST_CHECK);
  assign card_retain = (state_q == ST_LOCKED);
  assign tries_left  = tries_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pin_entry_auth.sv
// Bench for pin_entry_auth: table-driven PIN sessions, hand-written timing
// corners, and a randomized run checked every cycle against a session model.
module tb_pin_entry_auth;
  import pin_entry_auth_pkg::*;

  localparam int T = 16;
  localparam int P_IDLE = 0, P_COLLECT = 1, P_CHECK = 2, P_LOCKED = 3;

  logic        clk = 1'b0;
  logic        reset, start, abort, key_valid;
  logic [15:0] stored_pin;
  logic [3:0]  key_code;
  logic        key_ready, pin_ok, pin_bad, timeout, card_retain, busy;
  logic [2:0]  tries_left;
  state_t      state_dbg;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 0;

  always #5 clk = ~clk;

  pin_entry_auth #(.DIGITS(4), .MAX_TRIES(3), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stored_pin(stored_pin), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .pin_ok(pin_ok), .pin_bad(pin_bad),
    .timeout(timeout), .card_retain(card_retain), .busy(busy),
    .tries_left(tries_left), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: digits typed so far, card PIN digits, attempts, idle cycles.
  int m_phase = P_IDLE;
  int m_digits[$];
  int m_pin[4];
  int m_tries = 0;
  int m_idle = 0;
  bit m_ok = 0, m_bad = 0, m_to = 0;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_digits.delete();
    m_tries = 0;
    m_idle = 0;
    m_ok = 0; m_bad = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit good;
    m_ok = 0; m_bad = 0; m_to = 0;
    if (abort) begin
      m_phase = P_IDLE;
      m_digits.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          for (int i = 0; i < 4; i++) m_pin[i] = int'(stored_pin[15-4*i -: 4]);
          m_digits.delete();
          m_tries = 3;
          m_idle = 0;
          m_phase = P_COLLECT;
        end
        P_COLLECT: begin
          if (key_valid && key_code <= 4'hB) begin
            m_idle = 0;
            if (key_code <= 4'd9) begin
              if (m_digits.size() < 4) m_digits.push_back(int'(key_code));
            end else if (key_code == 4'hB) begin
              m_digits.delete();
            end else begin
              m_phase = P_CHECK;
            end
          end else if (m_idle == T - 1) begin
            m_to = 1;
            m_phase = P_IDLE;
          end else begin
            m_idle++;
          end
        end
        P_CHECK: begin
          good = (m_digits.size() == 4);
          if (good) for (int i = 0; i < 4; i++) if (m_digits[i] != m_pin[i]) good = 0;
          if (good) begin
            m_ok = 1;
            m_phase = P_IDLE;
          end else if (m_tries > 1) begin
            m_tries--;
            m_bad = 1;
            m_digits.delete();
            m_idle = 0;
            m_phase = P_COLLECT;
          end else begin
            m_tries = 0;
            m_phase = P_LOCKED;
          end
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (run_cmp)
      check("model_cycle",
            {key_ready, pin_ok, pin_bad, timeout, card_retain, busy, tries_left},
            {m_phase == P_COLLECT, m_ok, m_bad, m_to, m_phase == P_LOCKED,
             (m_phase == P_COLLECT) || (m_phase == P_CHECK), 3'(m_tries)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [3:0] c);
    int budget = 40;
    key_valid = 1'b1;
    key_code = c;
    while (!key_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("key_ready_wait", {31'b0, key_ready}, 32'd1);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic begin_session(input logic [15:0] pin);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    stored_pin = pin;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ready", {31'b0, key_ready}, 32'd1);
  endtask

  typedef struct {
    bit          new_session;
    logic [15:0] pin;
    logic [31:0] keys;     // first key in the MSBs
    int          nkeys;
    int          verdict;  // 0 ok, 1 bad, 2 locked
    int          tries;
  } vec_t;

  vec_t tbl[10];
  logic [8:0] exp_v;
  int early;
  bit quiet;
  int r;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; key_valid = 1'b0;
    key_code = 4'h0; stored_pin = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {key_ready, pin_ok, pin_bad, timeout, card_retain, busy, tries_left}, 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;
    run_cmp = 1;

    tbl[0] = '{1'b1, 16'h1234, 32'h1234A000, 5, 0, 3};
    tbl[1] = '{1'b1, 16'h1234, 32'h1235A000, 5, 1, 2};
    tbl[2] = '{1'b0, 16'h1234, 32'h1234A000, 5, 0, 2};
    tbl[3] = '{1'b1, 16'h1234, 32'h12B1234A, 8, 0, 3};
    tbl[4] = '{1'b1, 16'h1234, 32'h123A0000, 4, 1, 2};
    tbl[5] = '{1'b0, 16'h1234, 32'h12345A00, 6, 0, 2};
    tbl[6] = '{1'b1, 16'h9087, 32'h9087CA00, 6, 0, 3};
    tbl[7] = '{1'b1, 16'h1234, 32'h9999A000, 5, 1, 2};
    tbl[8] = '{1'b0, 16'h1234, 32'h9999A000, 5, 1, 1};
    tbl[9] = '{1'b0, 16'h1234, 32'h9999A000, 5, 2, 0};

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].new_session) begin_session(tbl[i].pin);
      for (int k = 0; k < tbl[i].nkeys; k++) send_key(tbl[i].keys[31-4*k -: 4]);
      check($sformatf("row%0d_check_cycle", i), {29'b0, busy, pin_ok, pin_bad}, 32'b100);
      tick();
      case (tbl[i].verdict)
        0: exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 5'(tbl[i].tries)};
        1: exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 5'(tbl[i].tries)};
        default: exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
      endcase
      check($sformatf("row%0d_verdict", i), {23'b0, pin_ok, pin_bad, card_retain, busy, 2'b0, tries_left},
            {23'b0, exp_v});
      tick();
      check($sformatf("row%0d_pulse_end", i), {30'b0, pin_ok, pin_bad}, 32'd0);
    end

    // Locked: keys are refused until abort.
    key_valid = 1'b1; key_code = 4'h1;
    repeat (3) tick();
    check("locked_hold", {28'b0, key_ready, card_retain, 32'(state_dbg) == 32'(ST_LOCKED), 1'b0}, 32'b0110);
    key_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_unlock", {29'b0, card_retain, busy, 32'(state_dbg) == 32'(ST_IDLE)}, 32'b001);

    // Timeout 16 cycles after the last key.
    begin_session(16'h1234);
    send_key(4'h1);
    early = 0;
    repeat (15) begin tick(); if (timeout || !key_ready) early++; end
    check("timeout_quiet", early, 0);
    tick();
    check("timeout_pulse", {26'b0, timeout, busy, key_ready, tries_left}, {26'b0, 3'b100, 3'd3});

    // Key arriving as the timer expires restarts the count.
    begin_session(16'h1234);
    send_key(4'h1);
    repeat (15) tick();
    send_key(4'h2);
    check("key_beats_expiry", {30'b0, timeout, key_ready}, 32'b01);
    early = 0;
    repeat (15) begin tick(); if (timeout) early++; end
    check("restart_quiet", early, 0);
    tick();
    check("restart_timeout", {31'b0, timeout}, 32'd1);

    // Enter together with abort.
    begin_session(16'h1234);
    send_key(4'h1); send_key(4'h2); send_key(4'h3); send_key(4'h4);
    key_valid = 1'b1; key_code = 4'hA; abort = 1'b1;
    tick();
    key_valid = 1'b0; abort = 1'b0;
    check("abort_enter_idle", {30'b0, busy, 32'(state_dbg) == 32'(ST_IDLE)}, 32'b01);
    tick();
    check("abort_enter_nopulse", {30'b0, pin_ok, pin_bad}, 32'd0);

    // Asynchronous reset in the middle of collection.
    begin_session(16'h1234);
    send_key(4'h5);
    #2 reset = 1'b1;
    #1;
    check("reset_async", {key_ready, pin_ok, pin_bad, timeout, card_retain, busy, tries_left}, 32'd0);
    check("reset_async_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    reset = 1'b0;

    // Randomized traffic; the per-cycle model comparison does the checking.
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) quiet = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < 4; j++) stored_pin[4*j +: 4] = 4'($urandom_range(0, 1));
      key_valid = quiet ? 1'b0 : 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      if (r <= 9 || r >= 14) key_code = 4'($urandom_range(0, 1));
      else if (r <= 11) key_code = 4'hA;
      else if (r == 12) key_code = 4'hB;
      else key_code = 4'($urandom_range(12, 15));
      tick();
    end
    abort = 1'b0; start = 1'b0; key_valid = 1'b0;
    tick();
    run_cmp = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
